// File: rtl/wb_arb2.sv
// Two-master Wiberbone arbiter for one shared slave. Round-robin on ties,
// bus lock while the owner holds cyc, and a slave-ack watchdog per grant.
module wb_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        own_stb_s;
    logic        timeout_s;

    // Strobe of whichever master currently owns the bus, and watchdog expiry.
    always_comb begin
        own_stb_s = 1'b0;
        case (state_q)
            GNT0:    own_stb_s = m0_stb_i;
            GNT1:    own_stb_s = m1_stb_i;
            default: own_stb_s = 1'b0;
        endcase
        timeout_s = (state_q != IDLE) && own_stb_s && !s_ack_i && (cnt_q == TO_LAST);
    end

    // Next-state, last-granted, watchdog and grant computation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = 8'd0;
        gnt_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (timeout_s) begin
                    state_d = IDLE;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (timeout_s) begin
                    state_d = IDLE;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The counter only runs while the same grant persists with an unanswered strobe.
        if ((state_q != IDLE) && own_stb_s && !s_ack_i && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end

        if ((state_d == GNT0) && (state_q != GNT0)) begin
            last_d = 1'b0;
        end else if ((state_d == GNT1) && (state_q != GNT1)) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end

        case (state_d)
            GNT0:    gnt_d = 2'b01;
            GNT1:    gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
    end

    // State registers with synchronous reset; last=1 lets m0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Combinational steering of the owner's bus to the slave and responses back.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_dat_o  = 32'd0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout_s;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout_s;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign gnt_o = gnt_q;

endmodule
